// File: rtl/rm_pkg.sv
// Shared types and constants for the fixed-point sphere-tracing renderer.
// All datapath values are 27-bit signed Q10.16 (1.0 = 65536).
package rm_pkg;

  typedef logic signed [26:0] fxp_t;

  localparam int   FRAC      = 16;
  localparam fxp_t ONE       = fxp_t'(1 << FRAC);
  localparam fxp_t EPS       = fxp_t'(655);
  localparam fxp_t T_MAX     = fxp_t'(1310720);
  localparam int   MAX_STEPS = 32;
  localparam int   H_RES     = 640;
  localparam int   V_RES     = 480;

  localparam logic [7:0] MISS_RED   = 8'h20;
  localparam logic [7:0] MISS_GREEN = 8'h20;
  localparam logic [7:0] MISS_BLUE  = 8'h40;

  typedef enum logic [2:0] {
    FRAME,
    DIR0,
    DIR1,
    DIR2,
    POS,
    SDF,
    OUT
  } state_t;

  // Wrapping absolute value: the most negative code maps onto itself.
  function automatic fxp_t fxp_abs(input fxp_t v);
    return v[26] ? -v : v;
  endfunction

endpackage

// File: rtl/fxp_mul.sv
// Combinational Q10.16 signed multiply: full 54-bit product, arithmetic
// shift right by FRAC, truncated back to the 27-bit format.
module fxp_mul
  import rm_pkg::*;
(
  input  fxp_t a,
  input  fxp_t b,
  output fxp_t p
);

  logic signed [53:0] full_prod;

  // Sign-extend both operands so the low 54 bits hold the exact signed product.
  assign full_prod = {{27{a[26]}}, a} * {{27{b[26]}}, b};
  assign p         = fxp_t'(full_prod >>> FRAC);

endmodule

// File: rtl/raymarcher.sv
// Sphere-tracing renderer: walks the frame in raster order, builds a camera
// ray per pixel, rotates it by the latched look-at matrix and marches it
// against a unit-half-size cube at the origin. One colour is emitted per pixel.
module raymarcher
  import rm_pkg::*;
#(
  parameter int H_PIX = H_RES,
  parameter int V_PIX = V_RES
) (
  input  logic       clk,
  input  logic       reset,
  input  fxp_t       look_at_1_1,
  input  fxp_t       look_at_1_2,
  input  fxp_t       look_at_1_3,
  input  fxp_t       look_at_2_1,
  input  fxp_t       look_at_2_2,
  input  fxp_t       look_at_2_3,
  input  fxp_t       look_at_3_1,
  input  fxp_t       look_at_3_2,
  input  fxp_t       look_at_3_3,
  input  fxp_t       eye_x,
  input  fxp_t       eye_y,
  input  fxp_t       eye_z,
  output logic [9:0] o_pixel_x,
  output logic [9:0] o_pixel_y,
  output logic [7:0] o_red,
  output logic [7:0] o_green,
  output logic [7:0] o_blue
);

  state_t     state;
  logic [9:0] pix_x;
  logic [9:0] pix_y;
  logic [4:0] steps;
  logic       hit;
  fxp_t       t;
  fxp_t       mat [9];
  fxp_t       eye [3];
  fxp_t       dir [3];
  fxp_t       pos [3];

  fxp_t cam [3];
  fxp_t mul_a [3];
  fxp_t mul_b [3];
  fxp_t mul_p [3];
  fxp_t dot;
  fxp_t abs_p [3];
  fxp_t max_xy;
  fxp_t max_xyz;
  fxp_t sdf;
  logic [7:0] grey;

  // Camera vector for the current pixel, centred on the middle of the frame.
  assign cam[0] = ($signed({17'd0, pix_x}) - fxp_t'(H_PIX / 2)) <<< 8;
  assign cam[1] = (fxp_t'(V_PIX / 2) - $signed({17'd0, pix_y})) <<< 8;
  assign cam[2] = ONE;

  // The three multipliers serve one matrix row per DIR state and t*d in POS.
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      mul_a[k] = t;
      mul_b[k] = dir[k];
    end
    case (state)
      DIR0: for (int k = 0; k < 3; k++) begin mul_a[k] = mat[k];     mul_b[k] = cam[k]; end
      DIR1: for (int k = 0; k < 3; k++) begin mul_a[k] = mat[3 + k]; mul_b[k] = cam[k]; end
      DIR2: for (int k = 0; k < 3; k++) begin mul_a[k] = mat[6 + k]; mul_b[k] = cam[k]; end
      default: ;
    endcase
  end

  fxp_mul u_mul0 (.a(mul_a[0]), .b(mul_b[0]), .p(mul_p[0]));
  fxp_mul u_mul1 (.a(mul_a[1]), .b(mul_b[1]), .p(mul_p[1]));
  fxp_mul u_mul2 (.a(mul_a[2]), .b(mul_b[2]), .p(mul_p[2]));

  assign dot = mul_p[0] + mul_p[1] + mul_p[2];

  // Cube distance estimate: Chebyshev norm of the march point minus the half-size.
  assign abs_p[0] = fxp_abs(pos[0]);
  assign abs_p[1] = fxp_abs(pos[1]);
  assign abs_p[2] = fxp_abs(pos[2]);
  assign max_xy   = (abs_p[0] > abs_p[1]) ? abs_p[0] : abs_p[1];
  assign max_xyz  = (max_xy > abs_p[2]) ? max_xy : abs_p[2];
  assign sdf      = max_xyz - ONE;

  // Hit shading darkens by eight levels per march step taken.
  assign grey = 8'd255 - {steps, 3'b000};

  // Pixel sequencer, march loop and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= FRAME;
      pix_x     <= '0;
      pix_y     <= '0;
      steps     <= '0;
      hit       <= 1'b0;
      t         <= '0;
      o_pixel_x <= '0;
      o_pixel_y <= '0;
      o_red     <= '0;
      o_green   <= '0;
      o_blue    <= '0;
      for (int k = 0; k < 9; k++) mat[k] <= '0;
      for (int k = 0; k < 3; k++) begin
        eye[k] <= '0;
        dir[k] <= '0;
        pos[k] <= '0;
      end
    end else begin
      case (state)
        FRAME: begin
          mat[0] <= look_at_1_1;
          mat[1] <= look_at_1_2;
          mat[2] <= look_at_1_3;
          mat[3] <= look_at_2_1;
          mat[4] <= look_at_2_2;
          mat[5] <= look_at_2_3;
          mat[6] <= look_at_3_1;
          mat[7] <= look_at_3_2;
          mat[8] <= look_at_3_3;
          eye[0] <= eye_x;
          eye[1] <= eye_y;
          eye[2] <= eye_z;
          state  <= DIR0;
        end
        DIR0: begin
          dir[0] <= dot;
          state  <= DIR1;
        end
        DIR1: begin
          dir[1] <= dot;
          state  <= DIR2;
        end
        DIR2: begin
          dir[2] <= dot;
          t      <= '0;
          steps  <= '0;
          state  <= POS;
        end
        POS: begin
          for (int k = 0; k < 3; k++) pos[k] <= eye[k] + mul_p[k];
          state <= SDF;
        end
        SDF: begin
          if (sdf < EPS) begin
            hit   <= 1'b1;
            state <= OUT;
          end else if (steps == 5'(MAX_STEPS - 1) || t > T_MAX) begin
            hit   <= 1'b0;
            state <= OUT;
          end else begin
            t     <= t + (sdf >>> 1);
            steps <= steps + 5'd1;
            state <= POS;
          end
        end
        OUT: begin
          o_pixel_x <= pix_x;
          o_pixel_y <= pix_y;
          o_red     <= hit ? grey : MISS_RED;
          o_green   <= hit ? grey : MISS_GREEN;
          o_blue    <= hit ? grey : MISS_BLUE;
          if (pix_x == 10'(H_PIX - 1)) begin
            pix_x <= '0;
            if (pix_y == 10'(V_PIX - 1)) begin
              pix_y <= '0;
              state <= FRAME;
            end else begin
              pix_y <= pix_y + 10'd1;
              state <= DIR0;
            end
          end else begin
            pix_x <= pix_x + 10'd1;
            state <= DIR0;
          end
        end
        default: state <= FRAME;
      endcase
    end
  end

endmodule

// File: tb/tb_raymarcher.sv
// Self-checking bench for raymarcher on a reduced 16x12 frame: every emitted
// pixel is compared against a plain-arithmetic sphere-tracing model.
module tb_raymarcher;

  localparam int H = 16;
  localparam int V = 12;
  localparam int NUM_SCENES = 6;
  localparam int NUM_FRAMES = 5;
  localparam int MAX_WAIT = 200;

  logic clk;
  logic reset;
  logic signed [26:0] look_at_1_1, look_at_1_2, look_at_1_3;
  logic signed [26:0] look_at_2_1, look_at_2_2, look_at_2_3;
  logic signed [26:0] look_at_3_1, look_at_3_2, look_at_3_3;
  logic signed [26:0] eye_x, eye_y, eye_z;
  logic [9:0] o_pixel_x, o_pixel_y;
  logic [7:0] o_red, o_green, o_blue;

  int check_count = 0;
  int err_count = 0;
  bit hung = 0;
  logic [43:0] prev_out;

  longint sc_m [NUM_SCENES][9];
  longint sc_e [NUM_SCENES][3];

  raymarcher #(.H_PIX(H), .V_PIX(V)) dut (
    .clk(clk), .reset(reset),
    .look_at_1_1(look_at_1_1), .look_at_1_2(look_at_1_2), .look_at_1_3(look_at_1_3),
    .look_at_2_1(look_at_2_1), .look_at_2_2(look_at_2_2), .look_at_2_3(look_at_2_3),
    .look_at_3_1(look_at_3_1), .look_at_3_2(look_at_3_2), .look_at_3_3(look_at_3_3),
    .eye_x(eye_x), .eye_y(eye_y), .eye_z(eye_z),
    .o_pixel_x(o_pixel_x), .o_pixel_y(o_pixel_y),
    .o_red(o_red), .o_green(o_green), .o_blue(o_blue)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expected);
    check_count++;
    if (got !== expected) begin
      err_count++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, expected);
    end
  endtask

  task automatic applyStimulus(input int sc);
    look_at_1_1 = 27'(sc_m[sc][0]); look_at_1_2 = 27'(sc_m[sc][1]); look_at_1_3 = 27'(sc_m[sc][2]);
    look_at_2_1 = 27'(sc_m[sc][3]); look_at_2_2 = 27'(sc_m[sc][4]); look_at_2_3 = 27'(sc_m[sc][5]);
    look_at_3_1 = 27'(sc_m[sc][6]); look_at_3_2 = 27'(sc_m[sc][7]); look_at_3_3 = 27'(sc_m[sc][8]);
    eye_x = 27'(sc_e[sc][0]); eye_y = 27'(sc_e[sc][1]); eye_z = 27'(sc_e[sc][2]);
  endtask

  function automatic longint wrap27(input longint v);
    longint r;
    r = v & 64'h7FF_FFFF;
    if (r >= 64'sd67108864) r = r - 64'sd134217728;
    return r;
  endfunction

  function automatic longint fmul(input longint a, input longint b);
    return wrap27((a * b) >>> 16);
  endfunction

  // Reference: build the ray, then march it with the distance rules directly.
  function automatic logic [23:0] model_pixel(input int sc, input int x, input int y);
    longint c [3];
    longint d [3];
    longint p [3];
    longint t, s, m, a;
    logic [7:0] g;
    c[0] = longint'(x - H / 2) * 256;
    c[1] = longint'(V / 2 - y) * 256;
    c[2] = 65536;
    for (int r = 0; r < 3; r++)
      d[r] = wrap27(fmul(sc_m[sc][3*r], c[0]) + fmul(sc_m[sc][3*r+1], c[1]) + fmul(sc_m[sc][3*r+2], c[2]));
    t = 0;
    for (int step = 0; step < 32; step++) begin
      m = -64'sd134217728;
      for (int k = 0; k < 3; k++) begin
        p[k] = wrap27(sc_e[sc][k] + fmul(t, d[k]));
        a = wrap27(p[k] < 0 ? -p[k] : p[k]);
        if (a > m) m = a;
      end
      s = wrap27(m - 65536);
      if (s < 655) begin
        g = 8'(255 - step * 8);
        return {g, g, g};
      end
      if (step == 31 || t > 1310720) return 24'h202040;
      t = wrap27(t + (s >>> 1));
    end
    return 24'h202040;
  endfunction

  task automatic wait_pixel(output bit ok);
    logic [43:0] cur;
    ok = 1'b0;
    for (int i = 0; i < MAX_WAIT; i++) begin
      @(negedge clk);
      cur = {o_pixel_x, o_pixel_y, o_red, o_green, o_blue};
      if (cur !== prev_out) begin
        prev_out = cur;
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checkOutput("pixel_timeout", 32'd0, 32'd1);
      hung = 1'b1;
    end
  endtask

  task automatic check_pixel(input int sc, input int x, input int y);
    checkOutput("pixel_x", 32'(o_pixel_x), 32'(x));
    checkOutput("pixel_y", 32'(o_pixel_y), 32'(y));
    checkOutput("rgb", 32'({o_red, o_green, o_blue}), 32'(model_pixel(sc, x, y)));
  endtask

  task automatic check_zero(input string tag);
    checkOutput(tag, 32'({o_pixel_x, o_pixel_y}) | 32'({o_red, o_green, o_blue}), 32'd0);
  endtask

  initial begin
    bit ok;
    // Scenes: identity matrix with eye at z=-4, eye inside the cube,
    // eye off to the side (all miss), two random scenes, identity again.
    for (int s = 0; s < NUM_SCENES; s++)
      for (int k = 0; k < 9; k++) sc_m[s][k] = (k % 4 == 0) ? 65536 : 0;
    sc_e[0][0] = 0;      sc_e[0][1] = 0; sc_e[0][2] = -262144;
    sc_e[1][0] = 0;      sc_e[1][1] = 0; sc_e[1][2] = 0;
    sc_e[2][0] = 196608; sc_e[2][1] = 0; sc_e[2][2] = -262144;
    sc_e[5][0] = 0;      sc_e[5][1] = 0; sc_e[5][2] = -262144;
    for (int s = 3; s < 5; s++) begin
      for (int k = 0; k < 9; k++) sc_m[s][k] = longint'($urandom_range(0, 131072)) - 65536;
      for (int k = 0; k < 3; k++) sc_e[s][k] = longint'($urandom_range(0, 524288)) - 262144;
    end

    reset = 1'b0;
    applyStimulus(0);
    repeat (3) @(negedge clk);
    check_zero("reset_outputs");
    prev_out = '0;
    reset = 1'b1;

    for (int f = 0; f < NUM_FRAMES && !hung; f++) begin
      for (int y = 0; y < V && !hung; y++) begin
        for (int x = 0; x < H && !hung; x++) begin
          wait_pixel(ok);
          if (ok) begin
            check_pixel(f, x, y);
            if (f == 0 && x == H / 2 && y == V / 2) checkOutput("centre_grey", 32'(o_red), 32'd183);
            if (f == 1) checkOutput("inside_white", 32'(o_green), 32'd255);
            if (f == 2) checkOutput("miss_colour", 32'({o_red, o_green, o_blue}), 32'h202040);
            if (x == 0 && y == 0) applyStimulus(f + 1);
          end
        end
      end
    end

    if (!hung) begin
      wait_pixel(ok);
      if (ok) check_pixel(NUM_FRAMES, 0, 0);
    end

    if (!hung) begin
      repeat (3) @(negedge clk);
      reset = 1'b0;
      #1;
      check_zero("async_reset_outputs");
      applyStimulus(1);
      repeat (3) @(negedge clk);
      check_zero("held_reset_outputs");
      prev_out = '0;
      reset = 1'b1;
      for (int x = 0; x < 3 && !hung; x++) begin
        wait_pixel(ok);
        if (ok) check_pixel(1, x, 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", err_count, check_count);
    $finish;
  end

endmodule
